// File: rtl/eth_pkg.sv
// Shared types and helpers for the Ethernet RX address filter.
package eth_pkg;

    typedef enum logic [1:0] {
        HEAD  = 2'd0,
        PASS  = 2'd1,
        DROP  = 2'd2,
        TRUNC = 2'd3
    } rx_state_t;

    localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;
    localparam int          MAC_BYTES = 6;

    localparam int NUM_CNT  = 5;
    localparam int CNT_OK   = 0;
    localparam int CNT_BAD  = 1;
    localparam int CNT_FILT = 2;
    localparam int CNT_RUNT = 3;
    localparam int CNT_OVSZ = 4;

    function automatic logic [3:0] keep_popcount(input logic [7:0] keep);
        logic [3:0] sum;
        sum = 4'd0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + {3'd0, keep[i]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/eth_axis_out_reg.sv
// Registered AXI-Stream output slice: one beat of storage, full throughput
// when the consumer is ready every cycle.
module eth_axis_out_reg #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [KEEP_WIDTH-1:0] in_keep,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic                  in_user,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready
);

    assign in_ready = !m_axis_tvalid || m_axis_tready;

    // Output beat register: load on accept, empty when the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tdata  <= {DATA_WIDTH{1'b0}};
            m_axis_tkeep  <= {KEEP_WIDTH{1'b0}};
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else if (in_valid && in_ready) begin
            m_axis_tdata  <= in_data;
            m_axis_tkeep  <= in_keep;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= in_last;
            m_axis_tuser  <= in_user;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/eth_rx_addr_filter.sv
// RX destination-MAC filter with oversize truncation and saturating
// per-class frame statistics; one beat per cycle, 1-cycle latency.
module eth_rx_addr_filter
    import eth_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int KEEP_WIDTH    = 8,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic [47:0]           cfg_mac,
    input  logic                  cfg_promisc,
    input  logic                  cfg_bcast_en,
    input  logic                  cfg_mcast_en,
    input  logic                  stat_clear,
    output logic [CNT_WIDTH-1:0]  stat_rx_ok,
    output logic [CNT_WIDTH-1:0]  stat_rx_bad,
    output logic [CNT_WIDTH-1:0]  stat_rx_filt,
    output logic [CNT_WIDTH-1:0]  stat_rx_runt,
    output logic [CNT_WIDTH-1:0]  stat_rx_ovsz
);

    rx_state_t            state;
    rx_state_t            next_state;
    logic [15:0]          byte_cnt;
    logic [16:0]          new_cnt;
    logic [47:0]          dst;
    logic                 is_bcast;
    logic                 match;
    logic                 runt;
    logic                 oversize;
    logic                 beat;
    logic                 out_ready;
    logic                 fwd;
    logic                 out_last;
    logic                 out_user;
    logic [NUM_CNT-1:0]   inc;
    logic [CNT_WIDTH-1:0] cnt [NUM_CNT];

    assign s_axis_tready = ((state == DROP) || (state == TRUNC)) ? 1'b1 : out_ready;
    assign beat          = s_axis_tvalid && s_axis_tready;

    assign dst      = s_axis_tdata[47:0];
    assign is_bcast = (dst == MAC_BCAST);
    assign match    = cfg_promisc || (dst == cfg_mac) || (cfg_bcast_en && is_bcast) ||
                      (cfg_mcast_en && s_axis_tdata[0] && !is_bcast);
    assign runt     = s_axis_tlast && !s_axis_tkeep[MAC_BYTES-1];

    // The running count restarts with every first beat, so no explicit clear is needed.
    assign new_cnt  = ((state == HEAD) ? 17'd0 : {1'b0, byte_cnt}) +
                      {13'd0, keep_popcount(s_axis_tkeep)};
    assign oversize = (new_cnt > 17'(MAX_FRAME_LEN)) && !s_axis_tlast;

    // Per-beat decision: forward or discard, frame-end classification, next state.
    always_comb begin
        next_state = state;
        fwd        = 1'b0;
        out_last   = s_axis_tlast;
        out_user   = s_axis_tuser;
        inc        = {NUM_CNT{1'b0}};
        case (state)
            HEAD: begin
                if (!beat) begin
                    next_state = HEAD;
                end else if (runt) begin
                    inc[CNT_RUNT] = 1'b1;
                end else if (!match) begin
                    inc[CNT_FILT] = s_axis_tlast;
                    next_state    = s_axis_tlast ? HEAD : DROP;
                end else begin
                    fwd        = 1'b1;
                    next_state = s_axis_tlast ? HEAD : PASS;
                end
            end
            PASS: begin
                fwd        = beat;
                next_state = (beat && s_axis_tlast) ? HEAD : PASS;
            end
            DROP: begin
                inc[CNT_FILT] = beat && s_axis_tlast;
                next_state    = (beat && s_axis_tlast) ? HEAD : DROP;
            end
            TRUNC: begin
                next_state = (beat && s_axis_tlast) ? HEAD : TRUNC;
            end
            default: begin
                next_state = HEAD;
            end
        endcase

        if (fwd && oversize) begin
            out_last      = 1'b1;
            out_user      = 1'b1;
            inc[CNT_OVSZ] = 1'b1;
            next_state    = TRUNC;
        end else begin
            out_last = out_last;
        end

        if (fwd && out_last) begin
            inc[CNT_OK]  = !out_user;
            inc[CNT_BAD] = out_user;
        end else begin
            inc[CNT_OK] = 1'b0;
        end
    end

    // Frame state and running byte count advance only on accepted beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HEAD;
            byte_cnt <= 16'd0;
        end else if (beat) begin
            state    <= next_state;
            byte_cnt <= new_cnt[15:0];
        end
    end

    // Saturating statistics; a clear in the same cycle as an increment wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt[i] <= {CNT_WIDTH{1'b0}};
            end
        end else if (stat_clear) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt[i] <= {CNT_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (inc[i] && (cnt[i] != {CNT_WIDTH{1'b1}})) begin
                    cnt[i] <= cnt[i] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign stat_rx_ok   = cnt[CNT_OK];
    assign stat_rx_bad  = cnt[CNT_BAD];
    assign stat_rx_filt = cnt[CNT_FILT];
    assign stat_rx_runt = cnt[CNT_RUNT];
    assign stat_rx_ovsz = cnt[CNT_OVSZ];

    eth_axis_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH)
    ) u_out_reg (
        .clk           (clk),
        .rst           (rst),
        .in_data       (s_axis_tdata),
        .in_keep       (s_axis_tkeep),
        .in_valid      (fwd),
        .in_last       (out_last),
        .in_user       (out_user),
        .in_ready      (out_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready)
    );

endmodule

// File: tb/tb_eth_rx_addr_filter.sv
// Scoreboard bench for eth_rx_addr_filter: directed filter/truncation/runt cases,
// then randomised traffic with output stalls; a 3-bit-counter copy checks saturation.
module tb_eth_rx_addr_filter;

    localparam int MAXLEN = 64;
    localparam int SCW    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] s_tdata = 64'd0;
    logic [7:0]  s_tkeep = 8'd0;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
    logic        s_tready, s_tready2;
    logic [63:0] m_tdata, m2_tdata;
    logic [7:0]  m_tkeep, m2_tkeep;
    logic        m_tvalid, m_tlast, m_tuser, m2_tvalid, m2_tlast, m2_tuser;
    logic        m_tready = 1'b1;
    logic [47:0] cfg_mac = 48'd0;
    logic        cfg_promisc = 1'b0, cfg_bcast_en = 1'b0, cfg_mcast_en = 1'b0;
    logic        stat_clear = 1'b0;
    logic [31:0] st_ok, st_bad, st_filt, st_runt, st_ovsz;
    logic [SCW-1:0] ss_ok, ss_bad, ss_filt, ss_runt, ss_ovsz;

    int checks = 0;
    int errors = 0;
    int ok_m = 0, bad_m = 0, filt_m = 0, runt_m = 0, ovsz_m = 0;
    bit rand_rdy = 1'b0;
    logic [73:0] exp_q[$];

    always #5 clk = ~clk;

    eth_rx_addr_filter #(.DATA_WIDTH(64), .KEEP_WIDTH(8), .MAX_FRAME_LEN(MAXLEN), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .cfg_mac(cfg_mac), .cfg_promisc(cfg_promisc), .cfg_bcast_en(cfg_bcast_en),
        .cfg_mcast_en(cfg_mcast_en), .stat_clear(stat_clear),
        .stat_rx_ok(st_ok), .stat_rx_bad(st_bad), .stat_rx_filt(st_filt),
        .stat_rx_runt(st_runt), .stat_rx_ovsz(st_ovsz)
    );

    eth_rx_addr_filter #(.DATA_WIDTH(64), .KEEP_WIDTH(8), .MAX_FRAME_LEN(MAXLEN), .CNT_WIDTH(SCW)) dut_sat (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready2), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m2_tdata), .m_axis_tkeep(m2_tkeep), .m_axis_tvalid(m2_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m2_tlast), .m_axis_tuser(m2_tuser),
        .cfg_mac(cfg_mac), .cfg_promisc(cfg_promisc), .cfg_bcast_en(cfg_bcast_en),
        .cfg_mcast_en(cfg_mcast_en), .stat_clear(stat_clear),
        .stat_rx_ok(ss_ok), .stat_rx_bad(ss_bad), .stat_rx_filt(ss_filt),
        .stat_rx_runt(ss_runt), .stat_rx_ovsz(ss_ovsz)
    );

    task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    // Output monitor: pops the scoreboard on every output handshake, then
    // picks the next m_tready value just after the active edge.
    initial begin
        logic [73:0] e;
        forever begin
            @(negedge clk);
            if (!rst && m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_beat", 80'd1, 80'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("out_beat", {m_tdata, m_tkeep, m_tlast, m_tuser}, e);
                    check_val("sat_copy_beat", {m2_tvalid, m2_tdata, m2_tkeep, m2_tlast, m2_tuser}, {1'b1, e});
                end
            end
            @(posedge clk);
            #1;
            m_tready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic [47:0] dst, input int len, input bit user, input bit clr);
        int nb = (len + 7) / 8;
        int cnt = 0;
        int n;
        int idx;
        int wait_c;
        bit is_b, mt, runt, fw, done, last, discard;
        logic [63:0] d;
        logic [7:0]  k;
        logic        lu;
        is_b = (dst == 48'hFFFF_FFFF_FFFF);
        mt   = cfg_promisc || (dst == cfg_mac) || (cfg_bcast_en && is_b) ||
               (cfg_mcast_en && dst[0] && !is_b);
        runt = (nb == 1) && (len < 6);
        fw   = !runt && mt;
        done = 1'b0;
        if (runt) runt_m++;
        else if (!mt) filt_m++;
        for (int b = 0; b < nb; b++) begin
            n = ((len - b * 8) > 8) ? 8 : (len - b * 8);
            for (int j = 0; j < 8; j++) begin
                idx = b * 8 + j;
                d[j*8 +: 8] = (idx < 6) ? dst[idx*8 +: 8] : 8'($urandom);
            end
            k    = 8'((16'h1 << n) - 16'h1);
            last = (b == nb - 1);
            lu   = last ? user : 1'b0;
            discard = (b > 0) && (!fw || done);
            if (fw && !done) begin
                cnt += n;
                if (cnt > MAXLEN && !last) begin
                    exp_q.push_back({d, k, 1'b1, 1'b1});
                    ovsz_m++;
                    bad_m++;
                    done = 1'b1;
                end else begin
                    exp_q.push_back({d, k, last, lu});
                    if (last && user) bad_m++;
                    else if (last) ok_m++;
                end
            end
            s_tvalid   = 1'b1;
            s_tdata    = d;
            s_tkeep    = k;
            s_tlast    = last;
            s_tuser    = lu;
            stat_clear = clr && last;
            @(negedge clk);
            if (discard) check_val("discard_ready", {79'd0, s_tready}, 80'd1);
            wait_c = 0;
            while (!s_tready && wait_c < 200) begin
                wait_c++;
                @(negedge clk);
            end
            if (!s_tready) check_val("s_ready_timeout", 80'd0, 80'd1);
            @(posedge clk);
            #1;
        end
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        s_tuser    = 1'b0;
        stat_clear = 1'b0;
        if (clr) begin
            ok_m = 0; bad_m = 0; filt_m = 0; runt_m = 0; ovsz_m = 0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) check_val("drain_timeout", 80'(exp_q.size()), 80'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check_val({tag, "_ok"},   80'(st_ok),   80'(ok_m));
        check_val({tag, "_bad"},  80'(st_bad),  80'(bad_m));
        check_val({tag, "_filt"}, 80'(st_filt), 80'(filt_m));
        check_val({tag, "_runt"}, 80'(st_runt), 80'(runt_m));
        check_val({tag, "_ovsz"}, 80'(st_ovsz), 80'(ovsz_m));
        check_val({tag, "_sat"}, {65'd0, ss_ok, ss_bad, ss_filt, ss_runt, ss_ovsz},
                  {65'd0, SCW'(sat(ok_m)), SCW'(sat(bad_m)), SCW'(sat(filt_m)),
                   SCW'(sat(runt_m)), SCW'(sat(ovsz_m))});
    endtask

    initial begin
        logic [47:0] rdst;
        repeat (3) @(negedge clk);
        check_val("reset_m_valid", {79'd0, m_tvalid}, 80'd0);
        check_val("reset_m_data", {m_tdata, m_tkeep, m_tlast, m_tuser}, 80'd0);
        check_val("reset_s_ready", {79'd0, s_tready}, 80'd1);
        check_counters("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        // wire order 02:00:00:00:00:01
        cfg_mac = 48'h01_00_00_00_00_02;
        repeat (2) @(posedge clk);
        #1;

        send_frame(cfg_mac, 64, 1'b0, 1'b0);
        drain();
        check_counters("t1_unicast");

        send_frame(48'h02_00_00_00_00_02, 64, 1'b0, 1'b0);
        drain();
        check_counters("t2_filtered");
        cfg_promisc = 1'b1;
        send_frame(48'h02_00_00_00_00_02, 64, 1'b0, 1'b0);
        drain();
        check_counters("t2_promisc");
        cfg_promisc = 1'b0;

        send_frame(48'hFFFF_FFFF_FFFF, 60, 1'b0, 1'b0);
        cfg_bcast_en = 1'b1;
        send_frame(48'hFFFF_FFFF_FFFF, 60, 1'b0, 1'b0);
        drain();
        check_counters("t3_bcast");
        send_frame(48'h01_00_00_5E_00_01, 40, 1'b0, 1'b0);
        cfg_mcast_en = 1'b1;
        send_frame(48'h01_00_00_5E_00_01, 40, 1'b1, 1'b0);
        drain();
        check_counters("t3_mcast");

        send_frame(cfg_mac, 80, 1'b0, 1'b0);
        drain();
        check_counters("t4_trunc");

        send_frame(cfg_mac, 5, 1'b0, 1'b0);
        send_frame(cfg_mac, 24, 1'b0, 1'b0);
        drain();
        check_counters("t5_runt");

        rand_rdy = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            if ($urandom_range(0, 15) == 0) begin
                cfg_promisc  = ($urandom_range(0, 3) == 0);
                cfg_bcast_en = $urandom_range(0, 1);
                cfg_mcast_en = $urandom_range(0, 1);
            end
            case ($urandom_range(0, 3))
                0: rdst = cfg_mac;
                1: rdst = 48'hFFFF_FFFF_FFFF;
                2: rdst = {16'($urandom), 24'($urandom), 7'($urandom), 1'b1};
                default: rdst = {16'($urandom), 24'($urandom), 7'($urandom), 1'b0};
            endcase
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send_frame(rdst, $urandom_range(1, 90), ($urandom_range(0, 7) == 0), 1'b0);
        end
        drain();
        check_counters("random");

        rand_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send_frame(cfg_mac, 64, 1'b0, 1'b1);
        drain();
        check_counters("clear");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
